linescanner_capture_controller: RTL

Parametrised line-scan sensor controller: drives the exposure sequence (rst_cvc, rst_cds, sample) with run-time programmable phase lengths, issues load_pulse after each ADC conversion, and captures the sensor's LVAL-framed pixel stream into a counted, validated, line-delimited output. Sits between the sensor pins and the downstream line buffer/DMA. Extends the fixed-timing capture unit with programmable timing, single-shot/continuous modes, pixel indexing, line length checking and line counting.

---
 rtl/linescanner_pkg.sv | 37 +++
 rtl/linescanner_pixel_capture.sv | 81 ++++++++
 rtl/linescanner_capture_controller.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/linescanner_pkg.sv
// ---------------------------------------------------------------------------
// linescanner_pkg
// Shared definitions for the line-scan capture controller: state encodings
// for the exposure and readout sequencers, power-up phase lengths and the
// helper that turns a programmed length of zero into one cycle.
// ---------------------------------------------------------------------------
package linescanner_pkg;

    typedef enum logic [2:0] {
        EXP_IDLE        = 3'd0,
        EXP_CVC_LOW     = 3'd1,
        EXP_CDS_LOW     = 3'd2,
        EXP_SAMPLE_HIGH = 3'd3,
        EXP_SAMPLE_LOW  = 3'd4
    } exp_state_t;

    typedef enum logic [2:0] {
        RD_WAIT_EOC      = 3'd0,
        RD_WAIT_LVAL_LOW = 3'd1,
        RD_DELAY         = 3'd2,
        RD_LOAD          = 3'd3,
        RD_WAIT_EOC_LOW  = 3'd4
    } rd_state_t;

    // Phase lengths held in the shadow registers until the first exposure
    localparam int DEFAULT_T_CVC     = 48;
    localparam int DEFAULT_T_CDS     = 7;
    localparam int DEFAULT_T_SAMPLE  = 48;
    localparam int DEFAULT_T_RELEASE = 6;
    localparam int DEFAULT_T_LOAD    = 3;

    // A phase can never be shorter than one cycle
    function automatic logic [31:0] clamp_len(input logic [31:0] value);
        return (value == 32'd0) ? 32'd1 : value;
    endfunction

endpackage

// File: rtl/linescanner_pixel_capture.sv
// ---------------------------------------------------------------------------
// linescanner_pixel_capture
// Registers the LVAL-framed sensor pixel stream, tags each pixel with its
// position in the line, and reports line completion, length errors and a
// wrapping count of completed lines.
//
// Ports:
//   pixel_clock   clock, rising edge
//   reset         synchronous, active-high
//   data, lval    sensor pixel bus and line-valid
//   pixel_valid   pixel_data / pixel_index valid (one cycle after lval)
//   pixel_data    registered pixel
//   pixel_index   position in line, saturates at LINE_PIXELS-1
//   line_done     one-cycle pulse one cycle after the last pixel_valid
//   line_len_err  last completed line length differed from LINE_PIXELS
//   line_count    completed lines, wraps
// ---------------------------------------------------------------------------
module linescanner_pixel_capture #(
    parameter int DATA_WIDTH     = 8,
    parameter int LINE_PIXELS    = 2048,
    parameter int LINE_CNT_WIDTH = 16,
    parameter int INDEX_WIDTH    = $clog2(LINE_PIXELS)
) (
    input  logic                      pixel_clock,
    input  logic                      reset,
    input  logic [DATA_WIDTH-1:0]     data,
    input  logic                      lval,
    output logic                      pixel_valid,
    output logic [DATA_WIDTH-1:0]     pixel_data,
    output logic [INDEX_WIDTH-1:0]    pixel_index,
    output logic                      line_done,
    output logic                      line_len_err,
    output logic [LINE_CNT_WIDTH-1:0] line_count
);

    // The pixel counter saturates one above the nominal length, which is
    // enough to tell short, exact and overrun lines apart.
    localparam int COUNT_WIDTH = $clog2(LINE_PIXELS + 2);
    localparam logic [COUNT_WIDTH-1:0] COUNT_FULL = COUNT_WIDTH'(LINE_PIXELS);
    localparam logic [COUNT_WIDTH-1:0] COUNT_SAT  = COUNT_WIDTH'(LINE_PIXELS + 1);
    localparam logic [INDEX_WIDTH-1:0] INDEX_MAX  = INDEX_WIDTH'(LINE_PIXELS - 1);

    logic                   lval_p0;
    logic [COUNT_WIDTH-1:0] pix_cnt;

    // ---- stage p0: sensor inputs -> registered pixel and line status ----
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            lval_p0      <= 1'b0;
            pix_cnt      <= '0;
            pixel_valid  <= 1'b0;
            pixel_data   <= '0;
            pixel_index  <= '0;
            line_done    <= 1'b0;
            line_len_err <= 1'b0;
            line_count   <= '0;
        end else begin
            lval_p0     <= lval;
            pixel_valid <= lval;
            // Falling edge of lval: pix_cnt still holds the finished line's length
            line_done   <= lval_p0 && !lval;

            if (lval) begin
                pixel_data  <= data;
                pixel_index <= (pix_cnt >= COUNT_FULL) ? INDEX_MAX
                                                       : pix_cnt[INDEX_WIDTH-1:0];
                if (pix_cnt != COUNT_SAT) begin
                    pix_cnt <= pix_cnt + COUNT_WIDTH'(1);
                end
            end else begin
                pix_cnt <= '0;
            end

            if (lval_p0 && !lval) begin
                line_count   <= line_count + LINE_CNT_WIDTH'(1);
                line_len_err <= (pix_cnt != COUNT_FULL);
            end
        end
    end

endmodule

// File: rtl/linescanner_capture_controller.sv
// ---------------------------------------------------------------------------
// linescanner_capture_controller
// Line-scan sensor controller. Sequences the exposure (rst_cvc, rst_cds,
// sample) with programmable phase lengths in single-shot or continuous mode,
// issues load_pulse after each ADC conversion, and captures the pixel stream
// through linescanner_pixel_capture.
//
// Ports:
//   pixel_clock, reset           clock and synchronous active-high reset
//   enable, start                continuous mode / single-shot trigger
//   t_cvc .. t_release, t_load   phase lengths in cycles (0 acts as 1)
//   data, lval, end_adc          sensor pixel bus, line valid, end of conversion
//   rst_cvc, rst_cds, sample     sensor exposure controls (resets active-low)
//   load_pulse                   one-cycle load strobe to the sensor
//   busy                         exposure in progress
//   pixel_valid .. line_count    captured pixel stream and line status
// ---------------------------------------------------------------------------
module linescanner_capture_controller
    import linescanner_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int LINE_PIXELS    = 2048,
    parameter int TIMER_WIDTH    = 8,
    parameter int LINE_CNT_WIDTH = 16
) (
    input  logic                           pixel_clock,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           start,
    input  logic [TIMER_WIDTH-1:0]         t_cvc,
    input  logic [TIMER_WIDTH-1:0]         t_cds,
    input  logic [TIMER_WIDTH-1:0]         t_sample,
    input  logic [TIMER_WIDTH-1:0]         t_release,
    input  logic [TIMER_WIDTH-1:0]         t_load,
    input  logic [DATA_WIDTH-1:0]          data,
    input  logic                           lval,
    input  logic                           end_adc,
    output logic                           rst_cvc,
    output logic                           rst_cds,
    output logic                           sample,
    output logic                           load_pulse,
    output logic                           busy,
    output logic                           pixel_valid,
    output logic [DATA_WIDTH-1:0]          pixel_data,
    output logic [$clog2(LINE_PIXELS)-1:0] pixel_index,
    output logic                           line_done,
    output logic                           line_len_err,
    output logic [LINE_CNT_WIDTH-1:0]      line_count
);

    localparam logic [TIMER_WIDTH-1:0] ONE = TIMER_WIDTH'(1);

    function automatic logic [TIMER_WIDTH-1:0] clamp_t(input logic [TIMER_WIDTH-1:0] value);
        return TIMER_WIDTH'(clamp_len(32'(value)));
    endfunction

    exp_state_t             exp_state;
    logic [TIMER_WIDTH-1:0] exp_cnt;
    rd_state_t              rd_state;
    logic [TIMER_WIDTH-1:0] rd_cnt;

    // The CVC length is consumed on the trigger edge, so only the later
    // phases need a shadow copy.
    logic [TIMER_WIDTH-1:0] sh_cds;
    logic [TIMER_WIDTH-1:0] sh_sample;
    logic [TIMER_WIDTH-1:0] sh_release;
    logic [TIMER_WIDTH-1:0] sh_load;

    // ---- exposure sequencer: counter reloads on each phase entry ----
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            exp_state  <= EXP_IDLE;
            exp_cnt    <= '0;
            rst_cvc    <= 1'b1;
            rst_cds    <= 1'b1;
            sample     <= 1'b0;
            busy       <= 1'b0;
            sh_cds     <= TIMER_WIDTH'(DEFAULT_T_CDS);
            sh_sample  <= TIMER_WIDTH'(DEFAULT_T_SAMPLE);
            sh_release <= TIMER_WIDTH'(DEFAULT_T_RELEASE);
            sh_load    <= TIMER_WIDTH'(DEFAULT_T_LOAD);
        end else begin
            case (exp_state)
                EXP_IDLE: begin
                    if (enable || start) begin
                        sh_cds     <= clamp_t(t_cds);
                        sh_sample  <= clamp_t(t_sample);
                        sh_release <= clamp_t(t_release);
                        sh_load    <= clamp_t(t_load);
                        exp_cnt    <= clamp_t(t_cvc) - ONE;
                        exp_state  <= EXP_CVC_LOW;
                        rst_cvc    <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                EXP_CVC_LOW: begin
                    if (exp_cnt == '0) begin
                        exp_cnt   <= sh_cds - ONE;
                        exp_state <= EXP_CDS_LOW;
                        rst_cds   <= 1'b0;
                    end else begin
                        exp_cnt <= exp_cnt - ONE;
                    end
                end
                EXP_CDS_LOW: begin
                    if (exp_cnt == '0) begin
                        exp_cnt   <= sh_sample - ONE;
                        exp_state <= EXP_SAMPLE_HIGH;
                        sample    <= 1'b1;
                    end else begin
                        exp_cnt <= exp_cnt - ONE;
                    end
                end
                EXP_SAMPLE_HIGH: begin
                    if (exp_cnt == '0) begin
                        exp_cnt   <= sh_release - ONE;
                        exp_state <= EXP_SAMPLE_LOW;
                        sample    <= 1'b0;
                    end else begin
                        exp_cnt <= exp_cnt - ONE;
                    end
                end
                EXP_SAMPLE_LOW: begin
                    // Returning to IDLE guarantees one cycle with both resets high
                    if (exp_cnt == '0) begin
                        exp_state <= EXP_IDLE;
                        rst_cvc   <= 1'b1;
                        rst_cds   <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        exp_cnt <= exp_cnt - ONE;
                    end
                end
                default: begin
                    exp_state <= EXP_IDLE;
                    rst_cvc   <= 1'b1;
                    rst_cds   <= 1'b1;
                    sample    <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // ---- readout sequencer: one load per end_adc high period ----
    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            rd_state   <= RD_WAIT_EOC;
            rd_cnt     <= '0;
            load_pulse <= 1'b0;
        end else begin
            case (rd_state)
                RD_WAIT_EOC: begin
                    if (end_adc) rd_state <= RD_WAIT_LVAL_LOW;
                end
                RD_WAIT_LVAL_LOW: begin
                    if (!lval) begin
                        rd_cnt   <= sh_load - ONE;
                        rd_state <= RD_DELAY;
                    end
                end
                RD_DELAY: begin
                    if (rd_cnt == '0) begin
                        rd_state   <= RD_LOAD;
                        load_pulse <= 1'b1;
                    end else begin
                        rd_cnt <= rd_cnt - ONE;
                    end
                end
                RD_LOAD: begin
                    rd_state   <= RD_WAIT_EOC_LOW;
                    load_pulse <= 1'b0;
                end
                RD_WAIT_EOC_LOW: begin
                    if (!end_adc) rd_state <= RD_WAIT_EOC;
                end
                default: begin
                    rd_state   <= RD_WAIT_EOC;
                    load_pulse <= 1'b0;
                end
            endcase
        end
    end

    linescanner_pixel_capture #(
        .DATA_WIDTH     (DATA_WIDTH),
        .LINE_PIXELS    (LINE_PIXELS),
        .LINE_CNT_WIDTH (LINE_CNT_WIDTH)
    ) u_pixel_capture (
        .pixel_clock  (pixel_clock),
        .reset        (reset),
        .data         (data),
        .lval         (lval),
        .pixel_valid  (pixel_valid),
        .pixel_data   (pixel_data),
        .pixel_index  (pixel_index),
        .line_done    (line_done),
        .line_len_err (line_len_err),
        .line_count   (line_count)
    );

endmodule
